// File: rtl/pio_tx_engine_if.sv
// rtl/pio_tx_engine_if.sv - Completer Completion stream bundle between the PIO engine and the PCIe core
interface pio_tx_engine_if #(
    parameter int C_DATA_WIDTH = 128,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32
);
    logic [C_DATA_WIDTH-1:0] s_axis_cc_tdata;
    logic [KEEP_WIDTH-1:0]   s_axis_cc_tkeep;
    logic                    s_axis_cc_tlast;
    logic                    s_axis_cc_tvalid;
    logic [32:0]             s_axis_cc_tuser;
    logic                    s_axis_cc_tready;

    modport master (
        output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
        output s_axis_cc_tvalid, s_axis_cc_tuser,
        input  s_axis_cc_tready
    );

    modport slave (
        input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
        input  s_axis_cc_tvalid, s_axis_cc_tuser,
        output s_axis_cc_tready
    );
endinterface

// File: rtl/pio_tx_engine.sv
// rtl/pio_tx_engine.sv - single-beat PIO read completion generator for BAR0/BAR1 with timeout abort
module pio_tx_engine #(
    parameter int C_DATA_WIDTH   = 128,
    parameter int KEEP_WIDTH     = C_DATA_WIDTH / 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        pcie_clk,
    input  logic        pcie_rst,
    input  logic [15:0] completer_id,
    input  logic        bar0_rd,
    input  logic [2:0]  bar0_req_tc,
    input  logic [2:0]  bar0_req_attr,
    input  logic [10:0] bar0_req_len,
    input  logic [15:0] bar0_req_rid,
    input  logic [7:0]  bar0_req_tag,
    input  logic [7:0]  bar0_req_be,
    input  logic [15:0] bar0_req_addr,
    input  logic [1:0]  bar0_req_at,
    input  logic        bar0_rd_valid,
    input  logic [31:0] bar0_rd_data,
    input  logic        bar1_rd,
    input  logic [2:0]  bar1_req_tc,
    input  logic [2:0]  bar1_req_attr,
    input  logic [10:0] bar1_req_len,
    input  logic [15:0] bar1_req_rid,
    input  logic [7:0]  bar1_req_tag,
    input  logic [7:0]  bar1_req_be,
    input  logic [15:0] bar1_req_addr,
    input  logic [1:0]  bar1_req_at,
    input  logic        bar1_rd_valid,
    input  logic [31:0] bar1_rd_data,
    pio_tx_engine_if.master cc,
    output logic        compl_done,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  timeout_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_DATA, SEND} state_t;

    typedef struct packed {
        logic        busy;
        logic        have_data;
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [10:0] len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [7:0]  be;
        logic [15:0] addr;
        logic [1:0]  at;
        logic [31:0] data;
    } slot_t;

    state_t                  state_q, state_d;
    slot_t [1:0]             slot_q, slot_d;
    logic                    sel_q, sel_d;
    logic [15:0]             timer_q, timer_d;
    logic [C_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
    logic                    tvalid_q, tvalid_d;
    logic                    done_q, done_d;
    logic [7:0]              drop_q, drop_d;
    logic [7:0]              tmo_q, tmo_d;

    slot_t [1:0]      req_in;
    logic [1:0]       rd_in, rv_in;
    logic [1:0][31:0] rdata_in;
    slot_t            cur;
    logic [1:0]       n_drop;
    logic [8:0]       drop_sum;

    assign req_in[0] = '{busy: 1'b1, have_data: bar0_rd_valid, tc: bar0_req_tc, attr: bar0_req_attr,
                         len: bar0_req_len, rid: bar0_req_rid, tag: bar0_req_tag, be: bar0_req_be,
                         addr: bar0_req_addr, at: bar0_req_at, data: bar0_rd_data};
    assign req_in[1] = '{busy: 1'b1, have_data: bar1_rd_valid, tc: bar1_req_tc, attr: bar1_req_attr,
                         len: bar1_req_len, rid: bar1_req_rid, tag: bar1_req_tag, be: bar1_req_be,
                         addr: bar1_req_addr, at: bar1_req_at, data: bar1_rd_data};
    assign rd_in    = {bar1_rd, bar0_rd};
    assign rv_in    = {bar1_rd_valid, bar0_rd_valid};
    assign rdata_in = {bar1_rd_data, bar0_rd_data};
    assign cur      = slot_q[sel_q];

    function automatic logic [1:0] lower_la(input logic [3:0] fbe);
        casez (fbe)
            4'b???1: lower_la = 2'b00;
            4'b??10: lower_la = 2'b01;
            4'b?100: lower_la = 2'b10;
            4'b1000: lower_la = 2'b11;
            default: lower_la = 2'b00;
        endcase
    endfunction

    // Multi-DW lengths are served as a single DW, so only the first BE sizes the transfer
    function automatic logic [12:0] byte_cnt(input logic [3:0] fbe);
        casez (fbe)
            4'b1??1:                   byte_cnt = 13'd4;
            4'b01?1, 4'b1?10:          byte_cnt = 13'd3;
            4'b0011, 4'b0110, 4'b1100: byte_cnt = 13'd2;
            default:                   byte_cnt = 13'd1;
        endcase
    endfunction

    function automatic logic [127:0] build_beat(input slot_t s, input logic ca, input logic [15:0] cid);
        logic [127:0] b;
        b          = '0;
        b[6:0]     = {s.addr[6:2], lower_la(s.be[3:0])};
        b[9:8]     = s.at;
        b[28:16]   = byte_cnt(s.be[3:0]);
        b[42:32]   = ca ? 11'd0 : 11'd1;
        b[45:43]   = ca ? 3'b100 : 3'b000;
        b[63:48]   = s.rid;
        b[71:64]   = s.tag;
        b[87:72]   = cid;
        b[88]      = 1'b1;
        b[91:89]   = s.tc;
        b[94:92]   = s.attr;
        b[127:96]  = ca ? 32'd0 : s.data;
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        sel_d    = sel_q;
        timer_d  = timer_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tvalid_d = tvalid_q;
        done_d   = 1'b0;
        tmo_d    = tmo_q;
        n_drop   = 2'd0;

        // Both slots capture independently of which one the FSM is serving
        for (int b = 0; b < 2; b++) begin
            if (!slot_q[b].busy) begin
                if (rd_in[b]) slot_d[b] = req_in[b];
            end else begin
                if (rv_in[b] && !slot_q[b].have_data) begin
                    slot_d[b].have_data = 1'b1;
                    slot_d[b].data      = rdata_in[b];
                end
                if (rd_in[b]) n_drop = n_drop + 2'd1;
            end
        end
        drop_sum = {1'b0, drop_q} + {7'd0, n_drop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        case (state_q)
            IDLE: begin
                timer_d = 16'd0;
                if (slot_q[0].busy) begin
                    sel_d   = 1'b0;
                    state_d = WAIT_DATA;
                end else if (slot_q[1].busy) begin
                    sel_d   = 1'b1;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (cur.have_data) begin
                    tdata_d  = build_beat(cur, 1'b0, completer_id);
                    tkeep_d  = 4'b1111;
                    tvalid_d = 1'b1;
                    state_d  = SEND;
                end else if (timer_q == 16'(TIMEOUT_CYCLES)) begin
                    tdata_d  = build_beat(cur, 1'b1, completer_id);
                    tkeep_d  = 4'b0111;
                    tvalid_d = 1'b1;
                    state_d  = SEND;
                    if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            SEND: begin
                if (cc.s_axis_cc_tready) begin
                    tvalid_d                = 1'b0;
                    done_d                  = 1'b1;
                    slot_d[sel_q].busy      = 1'b0;
                    slot_d[sel_q].have_data = 1'b0;
                    state_d                 = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            sel_q    <= 1'b0;
            timer_q  <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            sel_q    <= sel_d;
            timer_q  <= timer_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
            tmo_q    <= tmo_d;
        end
    end

    assign cc.s_axis_cc_tdata  = tdata_q;
    assign cc.s_axis_cc_tkeep  = tkeep_q;
    assign cc.s_axis_cc_tlast  = tvalid_q;
    assign cc.s_axis_cc_tvalid = tvalid_q;
    assign cc.s_axis_cc_tuser  = '0;
    assign compl_done          = done_q;
    assign drop_cnt            = drop_q;
    assign timeout_cnt         = tmo_q;
endmodule

// File: tb/tb_pio_tx_engine.sv
// tb/tb_pio_tx_engine.sv - randomized self-checking bench for pio_tx_engine against a completion model
module tb_pio_tx_engine;
    localparam int TMO = 8;

    typedef struct {
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [10:0] len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [7:0]  be;
        logic [15:0] addr;
        logic [1:0]  at;
        logic [31:0] data;
    } req_t;

    logic pcie_clk = 1'b0;
    logic pcie_rst;
    always #4 pcie_clk = ~pcie_clk;

    logic [15:0] completer_id;
    logic        bar0_rd, bar0_rd_valid, bar1_rd, bar1_rd_valid;
    logic [2:0]  bar0_req_tc, bar0_req_attr, bar1_req_tc, bar1_req_attr;
    logic [10:0] bar0_req_len, bar1_req_len;
    logic [15:0] bar0_req_rid, bar0_req_addr, bar1_req_rid, bar1_req_addr;
    logic [7:0]  bar0_req_tag, bar0_req_be, bar1_req_tag, bar1_req_be;
    logic [1:0]  bar0_req_at, bar1_req_at;
    logic [31:0] bar0_rd_data, bar1_rd_data;
    logic        compl_done;
    logic [7:0]  drop_cnt, timeout_cnt;

    pio_tx_engine_if #(.C_DATA_WIDTH(128)) cc ();

    pio_tx_engine #(.C_DATA_WIDTH(128), .KEEP_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst), .completer_id(completer_id),
        .bar0_rd(bar0_rd), .bar0_req_tc(bar0_req_tc), .bar0_req_attr(bar0_req_attr),
        .bar0_req_len(bar0_req_len), .bar0_req_rid(bar0_req_rid), .bar0_req_tag(bar0_req_tag),
        .bar0_req_be(bar0_req_be), .bar0_req_addr(bar0_req_addr), .bar0_req_at(bar0_req_at),
        .bar0_rd_valid(bar0_rd_valid), .bar0_rd_data(bar0_rd_data),
        .bar1_rd(bar1_rd), .bar1_req_tc(bar1_req_tc), .bar1_req_attr(bar1_req_attr),
        .bar1_req_len(bar1_req_len), .bar1_req_rid(bar1_req_rid), .bar1_req_tag(bar1_req_tag),
        .bar1_req_be(bar1_req_be), .bar1_req_addr(bar1_req_addr), .bar1_req_at(bar1_req_at),
        .bar1_rd_valid(bar1_rd_valid), .bar1_rd_data(bar1_rd_data),
        .cc(cc), .compl_done(compl_done), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_pulses = 0;
    bit rand_rdy = 1'b0;
    logic [127:0] obs_data[$];
    logic [3:0]   obs_keep[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge pcie_clk) cyc++;

    always @(negedge pcie_clk) begin
        if (!pcie_rst && cc.s_axis_cc_tvalid && cc.s_axis_cc_tready) begin
            obs_data.push_back(cc.s_axis_cc_tdata);
            obs_keep.push_back(cc.s_axis_cc_tkeep);
            check("tlast_on_beat", {127'd0, cc.s_axis_cc_tlast}, 128'd1);
            check("tuser_zero", {95'd0, cc.s_axis_cc_tuser}, 128'd0);
        end
        if (compl_done) done_pulses++;
    end

    always begin
        @(posedge pcie_clk);
        #1;
        if (rand_rdy) cc.s_axis_cc_tready = ($urandom_range(0, 3) != 0);
    end

    // Completion model: lower address from the lowest enabled byte, byte count as the enabled span
    function automatic logic [127:0] exp_beat(input req_t r, input bit ca);
        logic [127:0] b;
        logic [3:0]   fbe;
        int lo, hi, bc;
        fbe = r.be[3:0];
        lo = 0;
        hi = 0;
        for (int i = 3; i >= 0; i--) if (fbe[i]) lo = i;
        for (int i = 0; i < 4; i++) if (fbe[i]) hi = i;
        bc = (fbe == 4'd0) ? 1 : hi - lo + 1;
        b = '0;
        b[6:0]    = {r.addr[6:2], 2'(lo)};
        b[9:8]    = r.at;
        b[28:16]  = 13'(bc);
        b[42:32]  = ca ? 11'd0 : 11'd1;
        b[45:43]  = ca ? 3'd4 : 3'd0;
        b[63:48]  = r.rid;
        b[71:64]  = r.tag;
        b[87:72]  = completer_id;
        b[88]     = 1'b1;
        b[91:89]  = r.tc;
        b[94:92]  = r.attr;
        b[127:96] = ca ? 32'd0 : r.data;
        return b;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.tc   = 3'($urandom);
        r.attr = 3'($urandom);
        r.len  = 11'($urandom_range(1, 4));
        r.rid  = 16'($urandom);
        r.tag  = 8'($urandom);
        r.be   = 8'($urandom);
        r.addr = 16'($urandom) & 16'hFFFC;
        r.at   = 2'($urandom);
        r.data = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge pcie_clk);
        #1;
        bar0_rd = 1'b0;
        bar1_rd = 1'b0;
        bar0_rd_valid = 1'b0;
        bar1_rd_valid = 1'b0;
    endtask

    task automatic set_req(input int b, input req_t r);
        if (b == 0) begin
            bar0_rd = 1'b1; bar0_req_tc = r.tc; bar0_req_attr = r.attr; bar0_req_len = r.len;
            bar0_req_rid = r.rid; bar0_req_tag = r.tag; bar0_req_be = r.be;
            bar0_req_addr = r.addr; bar0_req_at = r.at;
        end else begin
            bar1_rd = 1'b1; bar1_req_tc = r.tc; bar1_req_attr = r.attr; bar1_req_len = r.len;
            bar1_req_rid = r.rid; bar1_req_tag = r.tag; bar1_req_be = r.be;
            bar1_req_addr = r.addr; bar1_req_at = r.at;
        end
    endtask

    task automatic set_data(input int b, input logic [31:0] d);
        if (b == 0) begin bar0_rd_valid = 1'b1; bar0_rd_data = d; end
        else begin bar1_rd_valid = 1'b1; bar1_rd_data = d; end
    endtask

    task automatic expect_beat(input string tag, input req_t r, input bit ca, output logic [127:0] got);
        int n;
        int d0;
        logic [3:0] k;
        n = 0;
        d0 = done_pulses;
        got = '0;
        while (obs_data.size() == 0 && n < 400) begin
            @(posedge pcie_clk);
            #1;
            n++;
        end
        if (obs_data.size() == 0) begin
            check({tag, "_arrived"}, 128'd0, 128'd1);
        end else begin
            got = obs_data.pop_front();
            k = obs_keep.pop_front();
            check({tag, "_tdata"}, got, exp_beat(r, ca));
            check({tag, "_tkeep"}, {124'd0, k}, ca ? 128'h7 : 128'hF);
            tick();
            tick();
            check({tag, "_done"}, 128'(done_pulses - d0), 128'd1);
        end
    endtask

    initial begin
        req_t r0, r1;
        logic [127:0] got, held;
        int c0, n;

        pcie_rst = 1'b1;
        completer_id = 16'h0A18;
        cc.s_axis_cc_tready = 1'b1;
        set_req(0, '{default: '0});
        set_req(1, '{default: '0});
        bar0_rd_data = '0;
        bar1_rd_data = '0;
        tick();
        tick();
        check("rst_tvalid", {127'd0, cc.s_axis_cc_tvalid}, 128'd0);
        check("rst_tdata", cc.s_axis_cc_tdata, 128'd0);
        check("rst_tkeep", {124'd0, cc.s_axis_cc_tkeep}, 128'd0);
        check("rst_done", {127'd0, compl_done}, 128'd0);
        check("rst_drop", {120'd0, drop_cnt}, 128'd0);
        check("rst_tmo", {120'd0, timeout_cnt}, 128'd0);
        pcie_rst = 1'b0;
        tick();

        // Directed first-BE cases with constants taken straight from the completion format
        r0 = '{tc: 3'd0, attr: 3'd0, len: 11'd1, rid: 16'h0100, tag: 8'h12, be: 8'h0F,
               addr: 16'h0010, at: 2'd0, data: 32'hDEADBEEF};
        set_req(0, r0);
        tick();
        tick();
        set_data(0, r0.data);
        tick();
        expect_beat("plain", r0, 1'b0, got);
        check("plain_la", {121'd0, got[6:0]}, 128'h10);
        check("plain_bc", {115'd0, got[28:16]}, 128'd4);
        check("plain_dw", {117'd0, got[42:32]}, 128'd1);
        check("plain_data", {96'd0, got[127:96]}, 128'hDEADBEEF);

        r0.addr = 16'h0008; r0.be = 8'h04; r0.tag = 8'h21;
        set_req(0, r0);
        set_data(0, r0.data);
        tick();
        expect_beat("be4", r0, 1'b0, got);
        check("be4_la", {121'd0, got[6:0]}, 128'h0A);
        check("be4_bc", {115'd0, got[28:16]}, 128'd1);

        r0.be = 8'h06; r0.tag = 8'h22;
        set_req(0, r0);
        set_data(0, r0.data);
        tick();
        expect_beat("be6", r0, 1'b0, got);
        check("be6_la", {121'd0, got[6:0]}, 128'h09);
        check("be6_bc", {115'd0, got[28:16]}, 128'd2);

        // Simultaneous BAR0/BAR1: BAR0 wins arbitration
        r0 = rand_req();
        r1 = rand_req();
        set_req(0, r0);
        set_req(1, r1);
        set_data(0, r0.data);
        set_data(1, r1.data);
        tick();
        expect_beat("dual_bar0", r0, 1'b0, got);
        expect_beat("dual_bar1", r1, 1'b0, got);
        check("dual_drop", {120'd0, drop_cnt}, 128'd0);

        // Second strobe into a busy slot is dropped
        r0 = rand_req();
        r1 = rand_req();
        r1.tag = r0.tag + 8'd1;
        set_req(0, r0);
        tick();
        set_req(0, r1);
        tick();
        tick();
        check("dbl_drop", {120'd0, drop_cnt}, 128'd1);
        set_data(0, r0.data);
        tick();
        expect_beat("dbl_first", r0, 1'b0, got);
        repeat (15) tick();
        check("dbl_no_second", 128'(obs_data.size()), 128'd0);

        // No read data: Completer Abort after the timeout
        r1 = rand_req();
        set_req(1, r1);
        tick();
        c0 = cyc;
        expect_beat("tmo", r1, 1'b1, got);
        check("tmo_status", {125'd0, got[45:43]}, 128'd4);
        check("tmo_dw", {117'd0, got[42:32]}, 128'd0);
        check("tmo_cnt", {120'd0, timeout_cnt}, 128'd1);
        check("tmo_window", {127'd0, ((cyc - c0) >= TMO + 2) && ((cyc - c0) <= TMO + 8)}, 128'd1);

        // Backpressure: beat held stable for 5 stalled cycles
        cc.s_axis_cc_tready = 1'b0;
        r0 = rand_req();
        set_req(0, r0);
        set_data(0, r0.data);
        tick();
        n = 0;
        while (!cc.s_axis_cc_tvalid && n < 50) begin tick(); n++; end
        check("stall_valid_seen", {127'd0, cc.s_axis_cc_tvalid}, 128'd1);
        held = cc.s_axis_cc_tdata;
        c0 = done_pulses;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_tvalid", {127'd0, cc.s_axis_cc_tvalid}, 128'd1);
            check("stall_tdata", cc.s_axis_cc_tdata, held);
        end
        check("stall_no_done", 128'(done_pulses - c0), 128'd0);
        cc.s_axis_cc_tready = 1'b1;
        expect_beat("stall", r0, 1'b0, got);

        // Randomized traffic with random backpressure and data latency
        rand_rdy = 1'b1;
        for (int it = 0; it < 24; it++) begin
            int b, dly;
            r0 = rand_req();
            b = $urandom_range(0, 1);
            dly = $urandom_range(0, 4);
            set_req(b, r0);
            if (dly == 0) set_data(b, r0.data);
            tick();
            if (dly != 0) begin
                repeat (dly - 1) tick();
                set_data(b, r0.data);
                tick();
            end
            expect_beat("rand", r0, 1'b0, got);
        end
        rand_rdy = 1'b0;
        #2;
        cc.s_axis_cc_tready = 1'b1;
        check("rand_drop", {120'd0, drop_cnt}, 128'd1);
        check("rand_tmo", {120'd0, timeout_cnt}, 128'd1);

        // Reset while a completion is pending
        cc.s_axis_cc_tready = 1'b0;
        r0 = rand_req();
        set_req(0, r0);
        set_data(0, r0.data);
        tick();
        n = 0;
        while (!cc.s_axis_cc_tvalid && n < 50) begin tick(); n++; end
        check("mid_valid_seen", {127'd0, cc.s_axis_cc_tvalid}, 128'd1);
        pcie_rst = 1'b1;
        tick();
        check("mid_rst_tvalid", {127'd0, cc.s_axis_cc_tvalid}, 128'd0);
        check("mid_rst_drop", {120'd0, drop_cnt}, 128'd0);
        pcie_rst = 1'b0;
        cc.s_axis_cc_tready = 1'b1;
        repeat (20) tick();
        check("mid_rst_no_beat", 128'(obs_data.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
